// File: rtl/blink_period_meter_pkg.sv
// Shared definitions for the blink period meter: FSM state encodings and the
// default timing constants that match the 1 Hz blink generator on a 50 MHz clock.
package blink_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } meter_state_e;

  localparam int unsigned DEF_CLK_HZ      = 50_000_000;
  localparam int unsigned DEF_BLINK_HZ    = 1;
  localparam int unsigned DEF_CNT_W       = 26;
  localparam int unsigned DEF_NOM_HALF    = DEF_CLK_HZ / (2 * DEF_BLINK_HZ);
  localparam int unsigned DEF_TOL         = DEF_NOM_HALF / 100;
  localparam int unsigned DEF_TIMEOUT_CYC = 2 * DEF_NOM_HALF;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/blink_period_meter_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input, plus a one-cycle-delayed
// copy and a combinational any-edge pulse derived from the two.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic s_o,
  output logic s_d_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s_d_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign s_d_o  = s_d_q;
  assign edge_o = sync_q[SYNC_STAGES-1] ^ s_d_q;

endmodule

// File: rtl/blink_period_meter.sv
// Measures each half-period of an external square wave in clock cycles,
// flags it against a nominal +/- tolerance window and reports loss of toggling.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | after reset; first edge only arms the counter
// ST_MEASURE | counting cycles since the last edge; each edge reports one
// ST_TIMEOUT | no edge for TIMEOUT_CYC cycles; counter frozen, next edge re-arms
module blink_period_meter
  import blink_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned NOM_HALF    = DEF_NOM_HALF,
  parameter int unsigned TOL         = DEF_TOL,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] half_period,
  output logic             level,
  output logic             meas_valid,
  output logic             in_spec,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W:0]   NOM_EXT = (CNT_W+1)'(NOM_HALF);
  localparam logic [CNT_W:0]   TOL_EXT = (CNT_W+1)'(TOL);

  logic s_w;
  logic s_d_w;
  logic edge_w;
  logic unused_s;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (sig_in),
    .s_o   (s_w),
    .s_d_o (s_d_w),
    .edge_o(edge_w)
  );

  assign unused_s = s_w;

  meter_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] half_period_q;
  logic             level_q;
  logic             meas_valid_q;
  logic             in_spec_q;
  logic             timeout_q;

  logic [CNT_W:0]   cnt_ext;
  logic [CNT_W:0]   dev;
  logic             within_tol;

  // One extra bit keeps the unsigned distance from wrapping for any counter value.
  always_comb begin
    cnt_ext    = {1'b0, cnt_q};
    dev        = (cnt_ext >= NOM_EXT) ? (cnt_ext - NOM_EXT) : (NOM_EXT - cnt_ext);
    within_tol = (dev <= TOL_EXT);
  end

  always_comb begin
    cnt_d = (cnt_q < CNT_TMO) ? (cnt_q + CNT_ONE) : cnt_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      half_period_q <= '0;
      level_q       <= 1'b0;
      meas_valid_q  <= 1'b0;
      in_spec_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (edge_w) begin
            state_q <= ST_MEASURE;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_MEASURE: begin
          // An edge landing on the timeout cycle still counts as a measurement.
          if (edge_w) begin
            half_period_q <= cnt_q;
            level_q       <= s_d_w;
            in_spec_q     <= within_tol;
            meas_valid_q  <= 1'b1;
            cnt_q         <= CNT_ONE;
          end else if (cnt_q >= CNT_TMO) begin
            state_q   <= ST_TIMEOUT;
            timeout_q <= 1'b1;
            in_spec_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_TIMEOUT: begin
          if (edge_w) begin
            state_q   <= ST_MEASURE;
            cnt_q     <= CNT_ONE;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign half_period = half_period_q;
  assign level       = level_q;
  assign meas_valid  = meas_valid_q;
  assign in_spec     = in_spec_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_blink_period_meter.sv
// Bench for blink_period_meter: drives toggle schedules (directed and random),
// predicts measurements from edge-to-edge gaps and compares pulse by pulse.
module tb_blink_period_meter;

  localparam int CNT_W = 10;
  localparam int NOM   = 100;
  localparam int TOL   = 5;
  localparam int TMO   = 400;
  localparam int SYNC  = 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             sig_in  = 1'b0;
  logic [CNT_W-1:0] half_period;
  logic             level;
  logic             meas_valid;
  logic             in_spec;
  logic             timeout;

  blink_period_meter #(
    .CNT_W(CNT_W), .NOM_HALF(NOM), .TOL(TOL), .TIMEOUT_CYC(TMO), .SYNC_STAGES(SYNC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sig_in(sig_in),
    .half_period(half_period), .level(level), .meas_valid(meas_valid),
    .in_spec(in_spec), .timeout(timeout)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [31:0] hp;
    logic        lvl;
    logic        ins;
  } meas_t;

  meas_t act_q[$];
  meas_t exp_q[$];
  int    gap_q[$];
  int    to_delta_q[$];
  logic  to_ins_q[$];
  int    exp_to;
  logic  exp_to_final;
  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    last_mv_cyc = 0;
  logic  prev_to  = 1'b0;
  meas_t mon_m;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: collect every measurement pulse and every timeout rising edge.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (meas_valid) begin
        mon_m.hp  = 32'(half_period);
        mon_m.lvl = level;
        mon_m.ins = in_spec;
        act_q.push_back(mon_m);
        last_mv_cyc = cyc;
      end
      if (timeout && !prev_to) begin
        to_delta_q.push_back(cyc - last_mv_cyc);
        to_ins_q.push_back(in_spec);
      end
    end
    prev_to = timeout;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    act_q.delete(); exp_q.delete(); gap_q.delete();
    to_delta_q.delete(); to_ins_q.delete();
    exp_to = 0; exp_to_final = 1'b0;
    last_mv_cyc = cyc;
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge sys_clk); #1 sys_rst = 1'b1;
    repeat (ncyc) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    clear_mon();
  endtask

  // Reference model: a gap is the number of cycles between consecutive input
  // changes. While armed, a gap up to TMO is one measurement of that gap at the
  // pre-edge level; a longer gap is a timeout and its closing edge only re-arms.
  task automatic run_gaps(input bit armed0, input int tail);
    bit    armed;
    logic  lvl;
    int    d;
    meas_t m;
    armed = armed0;
    lvl   = sig_in;
    foreach (gap_q[i]) begin
      if (armed && gap_q[i] > TMO) begin
        exp_to++;
        armed = 1'b0;
      end
      if (armed) begin
        d = gap_q[i] - NOM;
        if (d < 0) d = -d;
        m.hp  = 32'(gap_q[i]);
        m.lvl = lvl;
        m.ins = (d <= TOL);
        exp_q.push_back(m);
      end
      armed = 1'b1;
      lvl   = ~lvl;
      repeat (gap_q[i]) @(posedge sys_clk);
      #1 sig_in = ~sig_in;
    end
    exp_to_final = armed && (tail > TMO);
    if (exp_to_final) exp_to++;
    repeat (tail) @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sig_in = 1'b0;
    do_reset(3);
    n_assert++; if (half_period !== '0) begin n_fail++; $display("FAIL reset half_period: got %0d want 0", half_period); end
    n_assert++; if (level !== 1'b0) begin n_fail++; $display("FAIL reset level: got %0b want 0", level); end
    n_assert++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset meas_valid: got %0b want 0", meas_valid); end
    n_assert++; if (in_spec !== 1'b0) begin n_fail++; $display("FAIL reset in_spec: got %0b want 0", in_spec); end
    n_assert++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset timeout: got %0b want 0", timeout); end
  endtask

  task automatic test_nominal();
    sig_in = 1'b0;
    do_reset(2);
    gap_q = '{100, 100, 100, 100, 100, 100, 106, 106, 95, 95, 105, 94};
    run_gaps(1'b0, 150);
    n_assert++;
    if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL nominal count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_assert++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL nominal meas[%0d]: got hp=%0d lvl=%0b ins=%0b want hp=%0d lvl=%0b ins=%0b",
                 i, act_q[i].hp, act_q[i].lvl, act_q[i].ins, exp_q[i].hp, exp_q[i].lvl, exp_q[i].ins);
      end
    end
    n_assert++; if (to_delta_q.size() !== exp_to) begin n_fail++; $display("FAIL nominal timeouts: got %0d want %0d", to_delta_q.size(), exp_to); end
  endtask

  task automatic test_timeout();
    sig_in = 1'b0;
    do_reset(2);
    gap_q = '{100, 100, 100};
    run_gaps(1'b0, 500);
    n_assert++;
    if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL timeout count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_assert++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL timeout meas[%0d]: got hp=%0d lvl=%0b ins=%0b want hp=%0d lvl=%0b ins=%0b",
                 i, act_q[i].hp, act_q[i].lvl, act_q[i].ins, exp_q[i].hp, exp_q[i].lvl, exp_q[i].ins);
      end
    end
    n_assert++; if (to_delta_q.size() !== exp_to) begin n_fail++; $display("FAIL timeout rises: got %0d want %0d", to_delta_q.size(), exp_to); end
    if (to_delta_q.size() > 0) begin
      n_assert++; if (to_delta_q[0] !== TMO) begin n_fail++; $display("FAIL timeout delay: got %0d want %0d", to_delta_q[0], TMO); end
      n_assert++; if (to_ins_q[0] !== 1'b0) begin n_fail++; $display("FAIL timeout in_spec at rise: got %0b want 0", to_ins_q[0]); end
    end
    n_assert++; if (timeout !== exp_to_final) begin n_fail++; $display("FAIL timeout held: got %0b want %0b", timeout, exp_to_final); end
    n_assert++; if (half_period !== CNT_W'(NOM)) begin n_fail++; $display("FAIL timeout hp hold: got %0d want %0d", half_period, NOM); end
    clear_mon();
    gap_q = '{30, 100};
    run_gaps(1'b0, 150);
    n_assert++;
    if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL recover count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_assert++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL recover meas[%0d]: got hp=%0d lvl=%0b ins=%0b want hp=%0d lvl=%0b ins=%0b",
                 i, act_q[i].hp, act_q[i].lvl, act_q[i].ins, exp_q[i].hp, exp_q[i].lvl, exp_q[i].ins);
      end
    end
    n_assert++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL recover timeout: got %0b want 0", timeout); end
  endtask

  task automatic test_edge_at_timeout();
    sig_in = 1'b0;
    do_reset(2);
    gap_q = '{100, 400, 100, 401, 100, 100};
    run_gaps(1'b0, 150);
    n_assert++;
    if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL boundary count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_assert++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL boundary meas[%0d]: got hp=%0d lvl=%0b ins=%0b want hp=%0d lvl=%0b ins=%0b",
                 i, act_q[i].hp, act_q[i].lvl, act_q[i].ins, exp_q[i].hp, exp_q[i].lvl, exp_q[i].ins);
      end
    end
    n_assert++; if (to_delta_q.size() !== exp_to) begin n_fail++; $display("FAIL boundary timeouts: got %0d want %0d", to_delta_q.size(), exp_to); end
    if (to_delta_q.size() > 0) begin
      n_assert++; if (to_delta_q[0] !== TMO) begin n_fail++; $display("FAIL boundary timeout delay: got %0d want %0d", to_delta_q[0], TMO); end
    end
  endtask

  task automatic test_spurious_reset();
    sig_in = 1'b1;
    do_reset(3);
    gap_q = '{100, 100};
    run_gaps(1'b1, 150);
    n_assert++;
    if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL spurious count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_assert++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL spurious meas[%0d]: got hp=%0d lvl=%0b ins=%0b want hp=%0d lvl=%0b ins=%0b",
                 i, act_q[i].hp, act_q[i].lvl, act_q[i].ins, exp_q[i].hp, exp_q[i].lvl, exp_q[i].ins);
      end
    end
  endtask

  task automatic test_reset_mid();
    sig_in = 1'b0;
    do_reset(2);
    gap_q = '{40, 100};
    run_gaps(1'b0, 48);
    n_assert++; if (half_period !== CNT_W'(NOM)) begin n_fail++; $display("FAIL midreset pre hp: got %0d want %0d", half_period, NOM); end
    do_reset(1);
    n_assert++; if (half_period !== '0) begin n_fail++; $display("FAIL midreset half_period: got %0d want 0", half_period); end
    n_assert++; if (level !== 1'b0) begin n_fail++; $display("FAIL midreset level: got %0b want 0", level); end
    n_assert++; if (in_spec !== 1'b0) begin n_fail++; $display("FAIL midreset in_spec: got %0b want 0", in_spec); end
    n_assert++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL midreset meas_valid: got %0b want 0", meas_valid); end
    gap_q = '{70, 100, 100};
    run_gaps(1'b0, 150);
    n_assert++;
    if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midreset count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_assert++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midreset meas[%0d]: got hp=%0d lvl=%0b ins=%0b want hp=%0d lvl=%0b ins=%0b",
                 i, act_q[i].hp, act_q[i].lvl, act_q[i].ins, exp_q[i].hp, exp_q[i].lvl, exp_q[i].ins);
      end
    end
  endtask

  task automatic test_random();
    int r;
    int bnd[4];
    bnd = '{94, 95, 105, 106};
    sig_in = 1'b0;
    do_reset(2);
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      gap_q.push_back($urandom_range(401, 460));
      else if (r == 1) gap_q.push_back(TMO);
      else if (r < 6)  gap_q.push_back(bnd[$urandom_range(0, 3)]);
      else             gap_q.push_back($urandom_range(60, 140));
    end
    run_gaps(1'b0, 500);
    n_assert++;
    if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_assert++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random meas[%0d]: got hp=%0d lvl=%0b ins=%0b want hp=%0d lvl=%0b ins=%0b",
                 i, act_q[i].hp, act_q[i].lvl, act_q[i].ins, exp_q[i].hp, exp_q[i].lvl, exp_q[i].ins);
      end
    end
    n_assert++; if (to_delta_q.size() !== exp_to) begin n_fail++; $display("FAIL random timeouts: got %0d want %0d", to_delta_q.size(), exp_to); end
    foreach (to_ins_q[i]) begin
      n_assert++; if (to_ins_q[i] !== 1'b0) begin n_fail++; $display("FAIL random in_spec at timeout[%0d]: got %0b want 0", i, to_ins_q[i]); end
    end
    n_assert++; if (timeout !== exp_to_final) begin n_fail++; $display("FAIL random final timeout: got %0b want %0b", timeout, exp_to_final); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_edge_at_timeout();
    test_spurious_reset();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
